// File: rtl/sdr_tx_arbiter.sv
// Transmit-path arbiter: grants one Protocol-2 packet source at a time, holds the
// grant until the sender reports done, aborts stuck or orphaned grants, and enforces an idle gap.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  ST_IDLE | no grant; requests evaluated every cycle
//  ST_HOLD | grant registered and stable; watchdog timer counting down
//  ST_GAP  | grant withdrawn; IFG grant-free cycles before returning to IDLE
module sdr_tx_arbiter #(
    parameter int          NR      = 8,
    parameter logic [15:0] TIMEOUT = 16'd50000,
    parameter logic [3:0]  IFG     = 4'd2
) (
    input  logic          tx_clock,
    input  logic          reset_n,
    input  logic          run,
    input  logic          wideband,
    input  logic [7:0]    wb_pkts,
    input  logic          req_resp,
    input  logic          req_cc,
    input  logic          req_mic,
    input  logic          req_wb,
    input  logic [NR-1:0] req_ddc,
    input  logic          tx_done,
    output logic          grant_valid,
    output logic [4:0]    grant_id,
    output logic [NR-1:0] grant_ddc,
    output logic          abort,
    output logic          timeout_err,
    output logic          phy_ready
);

    localparam int RRW = (NR > 1) ? $clog2(NR) : 1;

    localparam logic [4:0] ID_RESP = 5'd0;
    localparam logic [4:0] ID_CC   = 5'd1;
    localparam logic [4:0] ID_MIC  = 5'd2;
    localparam logic [4:0] ID_WB   = 5'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            grant_valid_q, grant_valid_d;
    logic [4:0]      grant_id_q, grant_id_d;
    logic [NR-1:0]   grant_ddc_q, grant_ddc_d;
    logic            abort_q, abort_d;
    logic            timeout_err_q, timeout_err_d;
    logic            phy_ready_q, phy_ready_d;
    logic [RRW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [7:0]      wb_cnt_q, wb_cnt_d;
    logic [15:0]     tmr_q, tmr_d;
    logic [3:0]      gap_q, gap_d;

    // Round-robin search over DDC requests, starting at rr_ptr.
    logic            ddc_hit;
    logic [RRW-1:0]  ddc_sel;
    logic [RRW-1:0]  ddc_sel_next;

    always_comb begin
        int idx;
        int nxt;
        idx     = 0;
        nxt     = 0;
        ddc_hit = 1'b0;
        ddc_sel = '0;
        for (int i = 0; i < NR; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NR) begin
                idx = idx - NR;
            end
            if (!ddc_hit && req_ddc[idx]) begin
                ddc_hit = 1'b1;
                ddc_sel = RRW'(idx);
            end
        end
        nxt = int'(ddc_sel) + 1;
        if (nxt >= NR) begin
            nxt = 0;
        end
        ddc_sel_next = RRW'(nxt);
    end

    logic       wb_first;
    logic       wb_cont;
    logic [7:0] wb_lim;
    logic [8:0] wb_next;
    logic [7:0] wb_cnt_upd;

    assign wb_first   = wideband & req_wb & (wb_cnt_q == 8'd0);
    assign wb_cont    = wideband & req_wb & (wb_cnt_q != 8'd0) & (req_ddc == '0);
    assign wb_lim     = (wb_pkts == 8'd0) ? 8'd1 : wb_pkts;
    assign wb_next    = {1'b0, wb_cnt_q} + 9'd1;
    assign wb_cnt_upd = (wb_next >= {1'b0, wb_lim}) ? 8'd0 : wb_next[7:0];

    // Priority pick; everything except the response source requires run.
    logic          pick_valid;
    logic [4:0]    pick_id;
    logic [NR-1:0] pick_ddc;
    logic          pick_is_ddc;

    always_comb begin
        pick_valid  = 1'b0;
        pick_id     = ID_RESP;
        pick_ddc    = '0;
        pick_is_ddc = 1'b0;
        if (req_resp) begin
            pick_valid = 1'b1;
            pick_id    = ID_RESP;
        end else if (run) begin
            if (req_cc) begin
                pick_valid = 1'b1;
                pick_id    = ID_CC;
            end else if (req_mic) begin
                pick_valid = 1'b1;
                pick_id    = ID_MIC;
            end else if (wb_first) begin
                pick_valid = 1'b1;
                pick_id    = ID_WB;
            end else if (ddc_hit) begin
                pick_valid  = 1'b1;
                pick_is_ddc = 1'b1;
                pick_id     = 5'(4 + int'(ddc_sel));
                pick_ddc    = NR'(1) << ddc_sel;
            end else if (wb_cont) begin
                pick_valid = 1'b1;
                pick_id    = ID_WB;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_valid_d = grant_valid_q;
        grant_id_d    = grant_id_q;
        grant_ddc_d   = grant_ddc_q;
        abort_d       = 1'b0;
        timeout_err_d = timeout_err_q;
        rr_ptr_d      = rr_ptr_q;
        wb_cnt_d      = wb_cnt_q;
        tmr_d         = tmr_q;
        gap_d         = gap_q;
        phy_ready_d   = !(grant_valid_q && (grant_id_q >= 5'd4)) && (req_ddc == '0);

        case (state_q)
            ST_IDLE: begin
                if (!run) begin
                    rr_ptr_d      = '0;
                    wb_cnt_d      = 8'd0;
                    timeout_err_d = 1'b0;
                end
                if (pick_valid) begin
                    grant_valid_d = 1'b1;
                    grant_id_d    = pick_id;
                    grant_ddc_d   = pick_ddc;
                    tmr_d         = TIMEOUT - 16'd1;
                    state_d       = ST_HOLD;
                    if (pick_is_ddc) begin
                        rr_ptr_d = ddc_sel_next;
                    end
                end
            end

            ST_HOLD: begin
                // tx_done outranks both abort causes when they coincide.
                if (tx_done) begin
                    if (grant_id_q == ID_WB) begin
                        wb_cnt_d = wb_cnt_upd;
                    end
                    grant_valid_d = 1'b0;
                    grant_id_d    = ID_RESP;
                    grant_ddc_d   = '0;
                    gap_d         = IFG - 4'd1;
                    state_d       = ST_GAP;
                end else if (tmr_q == 16'd0) begin
                    abort_d       = 1'b1;
                    timeout_err_d = 1'b1;
                    grant_valid_d = 1'b0;
                    grant_id_d    = ID_RESP;
                    grant_ddc_d   = '0;
                    gap_d         = IFG - 4'd1;
                    state_d       = ST_GAP;
                end else if (!run && (grant_id_q != ID_RESP)) begin
                    abort_d       = 1'b1;
                    grant_valid_d = 1'b0;
                    grant_id_d    = ID_RESP;
                    grant_ddc_d   = '0;
                    gap_d         = IFG - 4'd1;
                    state_d       = ST_GAP;
                end else begin
                    tmr_d = tmr_q - 16'd1;
                end
            end

            ST_GAP: begin
                if (gap_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge tx_clock) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            grant_valid_q <= 1'b0;
            grant_id_q    <= 5'd0;
            grant_ddc_q   <= '0;
            abort_q       <= 1'b0;
            timeout_err_q <= 1'b0;
            phy_ready_q   <= 1'b1;
            rr_ptr_q      <= '0;
            wb_cnt_q      <= 8'd0;
            tmr_q         <= 16'd0;
            gap_q         <= 4'd0;
        end else begin
            state_q       <= state_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
            grant_ddc_q   <= grant_ddc_d;
            abort_q       <= abort_d;
            timeout_err_q <= timeout_err_d;
            phy_ready_q   <= phy_ready_d;
            rr_ptr_q      <= rr_ptr_d;
            wb_cnt_q      <= wb_cnt_d;
            tmr_q         <= tmr_d;
            gap_q         <= gap_d;
        end
    end

    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;
    assign grant_ddc   = grant_ddc_q;
    assign abort       = abort_q;
    assign timeout_err = timeout_err_q;
    assign phy_ready   = phy_ready_q;

endmodule
